// File: rtl/vc_arbitro_pkg.sv
// Shared definitions for the VC-to-destination scheduler and its FIFOs.
// The one-hot state encodings match the main FSM.
package vc_arbitro_pkg;

    localparam int DATA_W_DEF   = 6;
    localparam int DEST_BIT_DEF = 4;
    localparam int CONSEC_W     = 4;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    typedef enum logic [1:0] {
        ST_OFF = 2'b01,
        ST_RUN = 2'b10
    } state_e;

endpackage

// File: rtl/vc_arbitro_grant.sv
// Combinational eligibility and grant selection between VC0 and VC1.
// VC0 wins ties unless it has already taken MAX_CONSEC grants in a row.
module vc_arbitro_grant
    import vc_arbitro_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEST_BIT   = DEST_BIT_DEF,
    parameter int MAX_CONSEC = 4
) (
    input  logic [DATA_W-1:0]   vc0_data_i,
    input  logic [DATA_W-1:0]   vc1_data_i,
    input  logic                vc0_empty_i,
    input  logic                vc1_empty_i,
    input  logic                d0_almost_full_i,
    input  logic                d1_almost_full_i,
    input  logic [CONSEC_W-1:0] consec_i,
    output logic                gnt0_o,
    output logic                gnt1_o,
    output logic                elig1_o
);

    localparam logic [CONSEC_W-1:0] MAX_C = CONSEC_W'(MAX_CONSEC);

    logic af0;
    logic af1;
    logic elig0;
    logic elig1;

    // A head is blocked when its own destination is almost full.
    assign af0   = (vc0_data_i[DEST_BIT] == DEST_D1) ? d1_almost_full_i : d0_almost_full_i;
    assign af1   = (vc1_data_i[DEST_BIT] == DEST_D1) ? d1_almost_full_i : d0_almost_full_i;
    assign elig0 = !vc0_empty_i && !af0;
    assign elig1 = !vc1_empty_i && !af1;

    assign elig1_o = elig1;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (elig0 && elig1) begin
            if (consec_i == MAX_C) begin
                gnt1_o = 1'b1;
            end else begin
                gnt0_o = 1'b1;
            end
        end else begin
            gnt0_o = elig0;
            gnt1_o = elig1;
        end
    end

endmodule

// File: rtl/vc_arbitro.sv
// Scheduler moving head words from the two VC FIFOs into the D0/D1 FIFOs.
// Pops are combinational, pushes are registered one cycle later.
module vc_arbitro
    import vc_arbitro_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEST_BIT   = DEST_BIT_DEF,
    parameter int MAX_CONSEC = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              halt,
    input  logic              clr_cnt,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic              d1_push,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt_d0,
    output logic [CNT_W-1:0]  cnt_d1
);

    localparam logic [CONSEC_W-1:0] MAX_C = CONSEC_W'(MAX_CONSEC);

    state_e              state_q, state_d;
    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic                d0_push_q, d0_push_d;
    logic                d1_push_q, d1_push_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;

    logic run_ok;
    logic gnt0;
    logic gnt1;
    logic elig1;

    vc_arbitro_grant #(
        .DATA_W     (DATA_W),
        .DEST_BIT   (DEST_BIT),
        .MAX_CONSEC (MAX_CONSEC)
    ) u_grant (
        .vc0_data_i       (vc0_data),
        .vc1_data_i       (vc1_data),
        .vc0_empty_i      (vc0_empty),
        .vc1_empty_i      (vc1_empty),
        .d0_almost_full_i (d0_almost_full),
        .d1_almost_full_i (d1_almost_full),
        .consec_i         (consec_q),
        .gnt0_o           (gnt0),
        .gnt1_o           (gnt1),
        .elig1_o          (elig1)
    );

    // The leave-RUN condition suppresses pops in the same cycle it appears.
    assign run_ok = (state_q == ST_RUN) && enable && !halt;

    assign vc0_pop  = run_ok && gnt0;
    assign vc1_pop  = run_ok && gnt1;
    assign d0_push  = d0_push_q;
    assign d1_push  = d1_push_q;
    assign data_out = data_q;
    assign cnt_d0   = cnt0_q;
    assign cnt_d1   = cnt1_q;
    assign busy     = (state_q == ST_RUN) || d0_push_q || d1_push_q;

    always_comb begin
        state_d   = state_q;
        consec_d  = consec_q;
        data_d    = data_q;
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;

        case (state_q)
            ST_OFF:  if (enable && !halt) state_d = ST_RUN;
            ST_RUN:  if (!enable || halt) state_d = ST_OFF;
            default: state_d = ST_OFF;
        endcase

        if (vc0_pop) begin
            consec_d  = !elig1 ? '0 : (consec_q == MAX_C) ? consec_q : consec_q + CONSEC_W'(1);
            data_d    = vc0_data;
            d0_push_d = (vc0_data[DEST_BIT] == DEST_D0);
            d1_push_d = (vc0_data[DEST_BIT] == DEST_D1);
        end else if (vc1_pop) begin
            consec_d  = '0;
            data_d    = vc1_data;
            d0_push_d = (vc1_data[DEST_BIT] == DEST_D0);
            d1_push_d = (vc1_data[DEST_BIT] == DEST_D1);
        end

        // A clear beats an increment landing on the same edge.
        cnt0_d = clr_cnt ? '0 : cnt0_q + (d0_push_q ? CNT_W'(1) : CNT_W'(0));
        cnt1_d = clr_cnt ? '0 : cnt1_q + (d1_push_q ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_OFF;
            consec_q  <= '0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            data_q    <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            consec_q  <= consec_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
            data_q    <= data_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_vc_arbitro.sv
// Directed testbench for vc_arbitro: reset, anti-starvation, routing,
// backpressure, halt and counter behaviour against hand-computed values.
module tb_vc_arbitro;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       halt;
    logic       clr_cnt;
    logic       vc0_empty;
    logic       vc1_empty;
    logic [5:0] vc0_data;
    logic [5:0] vc1_data;
    logic       d0_almost_full;
    logic       d1_almost_full;
    logic       vc0_pop;
    logic       vc1_pop;
    logic       d0_push;
    logic       d1_push;
    logic [5:0] data_out;
    logic       busy;
    logic [7:0] cnt_d0;
    logic [7:0] cnt_d1;

    int nCompared   = 0;
    int nMismatched = 0;

    vc_arbitro dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .halt           (halt),
        .clr_cnt        (clr_cnt),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .vc0_data       (vc0_data),
        .vc1_data       (vc1_data),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .vc0_pop        (vc0_pop),
        .vc1_pop        (vc1_pop),
        .d0_push        (d0_push),
        .d1_push        (d1_push),
        .data_out       (data_out),
        .busy           (busy),
        .cnt_d0         (cnt_d0),
        .cnt_d1         (cnt_d1)
    );

    always #5 clk = ~clk;

    // Advance to just past the next rising edge so inputs change mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        tick();
        #1;
        nCompared++; if (vc0_pop !== 1'b0)  begin nMismatched++; $display("[TB] FAIL rst_vc0_pop got %b want 0", vc0_pop); end
        nCompared++; if (vc1_pop !== 1'b0)  begin nMismatched++; $display("[TB] FAIL rst_vc1_pop got %b want 0", vc1_pop); end
        nCompared++; if (d0_push !== 1'b0)  begin nMismatched++; $display("[TB] FAIL rst_d0_push got %b want 0", d0_push); end
        nCompared++; if (d1_push !== 1'b0)  begin nMismatched++; $display("[TB] FAIL rst_d1_push got %b want 0", d1_push); end
        nCompared++; if (data_out !== 6'h00) begin nMismatched++; $display("[TB] FAIL rst_data got %h want 00", data_out); end
        nCompared++; if (busy !== 1'b0)     begin nMismatched++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        nCompared++; if (cnt_d0 !== 8'd0)   begin nMismatched++; $display("[TB] FAIL rst_cnt_d0 got %0d want 0", cnt_d0); end
        nCompared++; if (cnt_d1 !== 8'd0)   begin nMismatched++; $display("[TB] FAIL rst_cnt_d1 got %0d want 0", cnt_d1); end
        reset = 1'b0;
    endtask

    task automatic test_reset_enable();
        enable = 1'b1; vc0_empty = 1'b0; vc0_data = 6'h03;
        tick();
        tick();
        tick();
        #1;
        nCompared++; if (cnt_d0 !== 8'd1) begin nMismatched++; $display("[TB] FAIL pre_rst_cnt got %0d want 1", cnt_d0); end
        reset = 1'b1;
        #1;
        nCompared++; if (d0_push !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_rst_push got %b want 0", d0_push); end
        nCompared++; if (cnt_d0 !== 8'd0)  begin nMismatched++; $display("[TB] FAIL async_rst_cnt got %0d want 0", cnt_d0); end
        nCompared++; if (vc0_pop !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_rst_pop got %b want 0", vc0_pop); end
        enable = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            nCompared++;
            if ({vc0_pop, vc1_pop, d0_push, d1_push, busy, data_out, cnt_d0, cnt_d1} !== 27'd0) begin
                nMismatched++;
                $display("[TB] FAIL idle_outputs cycle %0d got pops=%b%b push=%b%b busy=%b data=%h cnt=%0d/%0d want all 0",
                         i, vc0_pop, vc1_pop, d0_push, d1_push, busy, data_out, cnt_d0, cnt_d1);
            end
        end
        enable = 1'b1;
        #1;
        nCompared++; if (vc0_pop !== 1'b0) begin nMismatched++; $display("[TB] FAIL pop_in_off got %b want 0", vc0_pop); end
        tick();
        #1;
        nCompared++; if (vc0_pop !== 1'b1) begin nMismatched++; $display("[TB] FAIL first_pop got %b want 1", vc0_pop); end
        nCompared++; if (busy !== 1'b1)    begin nMismatched++; $display("[TB] FAIL run_busy got %b want 1", busy); end
        tick();
        #1;
        nCompared++; if (d0_push !== 1'b1)   begin nMismatched++; $display("[TB] FAIL first_push got %b want 1", d0_push); end
        nCompared++; if (data_out !== 6'h03) begin nMismatched++; $display("[TB] FAIL first_data got %h want 03", data_out); end
        enable = 1'b0; vc0_empty = 1'b1;
        tick();
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic test_starvation();
        logic [9:0] expVc1;
        logic       prevVc1;
        expVc1 = 10'b10_0001_0000;
        prevVc1 = 1'b0;
        vc0_empty = 1'b0; vc0_data = 6'h01;
        vc1_empty = 1'b0; vc1_data = 6'h02;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            nCompared++;
            if (vc0_pop !== !expVc1[i] || vc1_pop !== expVc1[i]) begin
                nMismatched++;
                $display("[TB] FAIL starve_pop %0d got vc0=%b vc1=%b want vc0=%b vc1=%b",
                         i, vc0_pop, vc1_pop, !expVc1[i], expVc1[i]);
            end
            if (i > 0) begin
                nCompared++;
                if (d0_push !== 1'b1 || d1_push !== 1'b0 || data_out !== (prevVc1 ? 6'h02 : 6'h01)) begin
                    nMismatched++;
                    $display("[TB] FAIL starve_push %0d got d0=%b d1=%b data=%h want d0=1 d1=0 data=%h",
                             i, d0_push, d1_push, data_out, prevVc1 ? 6'h02 : 6'h01);
                end
            end
            prevVc1 = expVc1[i];
            tick();
        end
        #1;
        nCompared++;
        if (d0_push !== 1'b1 || data_out !== 6'h02) begin
            nMismatched++;
            $display("[TB] FAIL starve_last_push got d0=%b data=%h want d0=1 data=02", d0_push, data_out);
        end
        enable = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1;
        tick();
        #1;
        nCompared++; if (cnt_d0 !== 8'd10) begin nMismatched++; $display("[TB] FAIL starve_cnt got %0d want 10", cnt_d0); end
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic test_routing();
        enable = 1'b1; vc0_empty = 1'b0; vc0_data = 6'h10;
        tick();
        #1;
        nCompared++; if (vc0_pop !== 1'b1) begin nMismatched++; $display("[TB] FAIL route_pop1 got %b want 1", vc0_pop); end
        tick();
        vc0_data = 6'h05;
        #1;
        nCompared++;
        if (d1_push !== 1'b1 || d0_push !== 1'b0 || data_out !== 6'h10) begin
            nMismatched++;
            $display("[TB] FAIL route_d1 got d0=%b d1=%b data=%h want d0=0 d1=1 data=10", d0_push, d1_push, data_out);
        end
        tick();
        vc0_empty = 1'b1;
        #1;
        nCompared++;
        if (d0_push !== 1'b1 || d1_push !== 1'b0 || data_out !== 6'h05) begin
            nMismatched++;
            $display("[TB] FAIL route_d0 got d0=%b d1=%b data=%h want d0=1 d1=0 data=05", d0_push, d1_push, data_out);
        end
        nCompared++; if (vc0_pop !== 1'b0) begin nMismatched++; $display("[TB] FAIL route_empty_pop got %b want 0", vc0_pop); end
        tick();
        #1;
        nCompared++; if (cnt_d1 !== 8'd1) begin nMismatched++; $display("[TB] FAIL route_cnt_d1 got %0d want 1", cnt_d1); end
        nCompared++; if (cnt_d0 !== 8'd1) begin nMismatched++; $display("[TB] FAIL route_cnt_d0 got %0d want 1", cnt_d0); end
    endtask

    task automatic test_backpressure();
        d0_almost_full = 1'b1;
        vc0_empty = 1'b0; vc0_data = 6'h01;
        vc1_empty = 1'b0; vc1_data = 6'h13;
        #1;
        nCompared++;
        if (vc0_pop !== 1'b0 || vc1_pop !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL bp_pop got vc0=%b vc1=%b want vc0=0 vc1=1", vc0_pop, vc1_pop);
        end
        tick();
        #1;
        nCompared++;
        if (d1_push !== 1'b1 || data_out !== 6'h13 || vc0_pop !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_push got d1=%b data=%h vc0_pop=%b want d1=1 data=13 vc0_pop=0", d1_push, data_out, vc0_pop);
        end
        tick();
        d0_almost_full = 1'b0;
        #1;
        nCompared++;
        if (vc0_pop !== 1'b1 || vc1_pop !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_resume got vc0=%b vc1=%b want vc0=1 vc1=0", vc0_pop, vc1_pop);
        end
        tick();
        #1;
        nCompared++;
        if (d0_push !== 1'b1 || data_out !== 6'h01) begin
            nMismatched++;
            $display("[TB] FAIL bp_resume_push got d0=%b data=%h want d0=1 data=01", d0_push, data_out);
        end
        enable = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_halt();
        enable = 1'b1; vc0_empty = 1'b0; vc0_data = 6'h07;
        tick();
        #1;
        nCompared++; if (vc0_pop !== 1'b1) begin nMismatched++; $display("[TB] FAIL halt_pre_pop got %b want 1", vc0_pop); end
        tick();
        halt = 1'b1;
        #1;
        nCompared++;
        if (vc0_pop !== 1'b0 || d0_push !== 1'b1 || data_out !== 6'h07 || busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL halt_pending got pop=%b push=%b data=%h busy=%b want pop=0 push=1 data=07 busy=1",
                     vc0_pop, d0_push, data_out, busy);
        end
        tick();
        #1;
        nCompared++;
        if (vc0_pop !== 1'b0 || d0_push !== 1'b0 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL halt_idle got pop=%b push=%b busy=%b want 0 0 0", vc0_pop, d0_push, busy);
        end
        tick();
        #1;
        nCompared++; if (vc0_pop !== 1'b0) begin nMismatched++; $display("[TB] FAIL halt_hold_pop got %b want 0", vc0_pop); end
        halt = 1'b0; enable = 1'b0; vc0_empty = 1'b1;
        tick();
    endtask

    task automatic test_counter_wrap();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        enable = 1'b1; vc0_empty = 1'b0; vc0_data = 6'h01;
        tick();
        repeat (256) tick();
        enable = 1'b0; vc0_empty = 1'b1;
        #1;
        nCompared++; if (vc0_pop !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_stop_pop got %b want 0", vc0_pop); end
        nCompared++; if (cnt_d0 !== 8'd255) begin nMismatched++; $display("[TB] FAIL wrap_pre got %0d want 255", cnt_d0); end
        tick();
        #1;
        nCompared++; if (cnt_d0 !== 8'd0) begin nMismatched++; $display("[TB] FAIL wrap_zero got %0d want 0", cnt_d0); end
        tick();
        enable = 1'b1; vc0_empty = 1'b0;
        tick();
        tick();
        tick();
        tick();
        enable = 1'b0; vc0_empty = 1'b1; clr_cnt = 1'b1;
        #1;
        nCompared++;
        if (d0_push !== 1'b1 || cnt_d0 !== 8'd2) begin
            nMismatched++;
            $display("[TB] FAIL clr_pre got push=%b cnt=%0d want push=1 cnt=2", d0_push, cnt_d0);
        end
        tick();
        clr_cnt = 1'b0;
        #1;
        nCompared++; if (cnt_d0 !== 8'd0) begin nMismatched++; $display("[TB] FAIL clr_wins got %0d want 0", cnt_d0); end
        tick();
        #1;
        nCompared++; if (cnt_d0 !== 8'd0) begin nMismatched++; $display("[TB] FAIL clr_hold got %0d want 0", cnt_d0); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; halt = 1'b0; clr_cnt = 1'b0;
        vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = 6'h00; vc1_data = 6'h00;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        test_reset();
        test_reset_enable();
        test_starvation();
        test_routing();
        test_backpressure();
        test_halt();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
